// File: rtl/rcs_seq_pkg.sv
// Shared definitions for the sequential ripple-carry subtractor controller.
// State encodings, default widths and the slice-index width helper.
package rcs_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index register is at least one bit wide, even for a single-slice build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rcs_slice.sv
// Combinational SLICE-bit ripple-carry subtractor: {bout, d} = a - b - bin.
module rcs_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE:0] br;

  always_comb begin
    br    = '0;
    d     = '0;
    br[0] = bin;
    for (int i = 0; i < SLICE; i++) begin
      d[i]    = a[i] ^ b[i] ^ br[i];
      br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
  end

  assign bout = br[SLICE];

endmodule

// File: rtl/rcs_seq_ctrl.sv
// Time-shared subtractor: diff = a - b computed one SLICE per cycle, LSB first.
// Optional RCS_SEQ_FLAGS_EN adds zero and signed-overflow result flags.
//
// state  | meaning
// S_IDLE | ready for operands, last result retained on diff/borrow
// S_RUN  | one slice pass per cycle, borrow chained through bin
// S_DONE | result presented with out_valid until out_ready
module rcs_seq_ctrl
  import rcs_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef RCS_SEQ_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             borrow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = idx_w(NSLICE);
  localparam logic [IW-1:0] IDX_LAST = IW'(NSLICE - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic             bin;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [SLICE-1:0] s_a;
  logic [SLICE-1:0] s_b;
  logic [SLICE-1:0] s_d;
  logic             s_bout;
  logic [WIDTH-1:0] diff_nxt;

  assign s_a = a_q[idx*SLICE +: SLICE];
  assign s_b = b_q[idx*SLICE +: SLICE];

  rcs_slice #(.SLICE(SLICE)) u_slice (
    .a    (s_a),
    .b    (s_b),
    .bin  (bin),
    .d    (s_d),
    .bout (s_bout)
  );

  // Full result as it will look after this pass; lets flags see the final slice.
  always_comb begin
    diff_nxt = diff;
    diff_nxt[idx*SLICE +: SLICE] = s_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      bin       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef RCS_SEQ_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            idx      <= '0;
            bin      <= 1'b0;
            borrow   <= 1'b0;
            in_ready <= 1'b0;
            state    <= S_RUN;
`ifdef RCS_SEQ_FLAGS_EN
            zero     <= 1'b0;
            ovf      <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          diff <= diff_nxt;
          bin  <= s_bout;
          if (idx == IDX_LAST) begin
            idx       <= '0;
            borrow    <= s_bout;
            out_valid <= 1'b1;
            state     <= S_DONE;
`ifdef RCS_SEQ_FLAGS_EN
            zero      <= (diff_nxt == '0);
            ovf       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                         (s_d[SLICE-1] != a_q[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcs_seq_ctrl.sv
// Self-checking bench for rcs_seq_ctrl: directed table, hold/reset sequences, random ops.
// Flag checks compile in when RCS_SEQ_FLAGS_EN is defined.
module tb_rcs_seq_ctrl;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef RCS_SEQ_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rcs_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef RCS_SEQ_FLAGS_EN
    .zero      (zero),
    .ovf       (ovf),
`endif
    .borrow    (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic logic [WIDTH-1:0] m_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return x - y;
  endfunction

  function automatic logic m_borrow(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return x < y;
  endfunction

  function automatic logic m_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint sd;
    sd = longint'($signed(x)) - longint'($signed(y));
    return (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
  endfunction

  // Present operands for one handshake; returns at the negedge after the accept edge.
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2);
    @(negedge clk);
    chk("in_ready_before_op", in_ready, 1);
    in_valid = 1'b1;
    a_i      = ta;
    b_i      = tb2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
  endtask

  task automatic wait_result(input string nm);
    int n;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, NSLICE + 1);
  endtask

  task automatic check_result(input string nm, input logic [WIDTH-1:0] ta,
                              input logic [WIDTH-1:0] tb2);
    chk({nm, "_out_valid"}, out_valid, 1);
    chk({nm, "_diff"}, diff, m_diff(ta, tb2));
    chk({nm, "_borrow"}, borrow, m_borrow(ta, tb2));
    chk({nm, "_in_ready_busy"}, in_ready, 0);
`ifdef RCS_SEQ_FLAGS_EN
    chk({nm, "_zero"}, zero, (ta == tb2));
    chk({nm, "_ovf"}, ovf, m_ovf(ta, tb2));
`endif
  endtask

  task automatic accept(input string nm);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_out_valid_drop"}, out_valid, 0);
    chk({nm, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] held;
    logic             held_b;
    bit               spurious;

    vecs[0] = '{a: 32'd5,          b: 32'd3,          diff: 32'h0000_0002, borrow: 1'b0};
    vecs[1] = '{a: 32'd0,          b: 32'd1,          diff: 32'hFFFF_FFFF, borrow: 1'b1};
    vecs[2] = '{a: 32'h0001_0000,  b: 32'd1,          diff: 32'h0000_FFFF, borrow: 1'b0};
    vecs[3] = '{a: 32'h8000_0000,  b: 32'd1,          diff: 32'h7FFF_FFFF, borrow: 1'b0};
    vecs[4] = '{a: 32'h0000_1234,  b: 32'h0000_1234,  diff: 32'h0000_0000, borrow: 1'b0};
    vecs[5] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  diff: 32'h0000_0000, borrow: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_i       = '0;
    b_i       = '0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_diff", diff, 0);
    chk("reset_borrow", borrow, 0);
`ifdef RCS_SEQ_FLAGS_EN
    chk("reset_zero", zero, 0);
    chk("reset_ovf", ovf, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result("table");
      chk("table_diff", diff, vecs[i].diff);
      chk("table_borrow", borrow, vecs[i].borrow);
      check_result("table_model", vecs[i].a, vecs[i].b);
      accept("table");
    end

    // Result held under back-pressure; busy in_valid ignored
    start_op(32'd100, 32'd250);
    wait_result("hold");
    held   = diff;
    held_b = borrow;
    chk("hold_diff_value", held, m_diff(32'd100, 32'd250));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a_i      = 32'd9;
      b_i      = 32'd9;
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_diff", diff, held);
      chk("hold_borrow", borrow, held_b);
      chk("hold_in_ready", in_ready, 0);
    end
    accept("hold");
    chk("retain_diff_after_accept", diff, held);
    chk("retain_borrow_after_accept", borrow, held_b);
    repeat (3) @(negedge clk);
    chk("no_stray_accept", in_ready, 1);

    // Async reset during the second RUN cycle
    start_op(32'h1234_5678, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_borrow", borrow, 0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    chk("midrst_no_result", spurious, 0);
    start_op(32'd7, 32'd2);
    wait_result("post_rst");
    chk("post_rst_diff", diff, 32'd5);
    check_result("post_rst", 32'd7, 32'd2);
    accept("post_rst");

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = {1'b1, 31'($urandom)};
        2: rb = ra + 32'd1;
        default: ;
      endcase
      start_op(ra, rb);
      wait_result("rand");
      check_result("rand", ra, rb);
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom);
        a_i      = $urandom;
        b_i      = $urandom;
        @(negedge clk);
        chk("rand_hold_diff", diff, m_diff(ra, rb));
      end
      accept("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
